bcd_tick_counter: RTL and testbench
===================================

Name: bcd_tick_counter

Overview:
- Parametrised successor to the single-digit tick-driven decade counter.
- One clock domain throughout: a prescaler divides iCLK down to a one-cycle tick enable, and a chain of DIGITS cascaded BCD digits counts on that tick.
- Adds up/down counting, parallel load, synchronous clear, count enable and a wrap/carry pulse.
- Feeds display multiplexers and timers elsewhere in the design.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 4, tick rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be an integer >= 2 (elaboration error otherwise).
- DIGITS, 2, number of cascaded BCD digits, 1..8.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iEN  in  1  count enable, sampled only on tick cycles.
- iUP  in  1  direction: 1 = up, 0 = down.
- iCLR  in  1  synchronous clear of counter and prescaler.
- iLOAD  in  1  synchronous parallel load of counter.
- iLOAD_VAL  in  4*DIGITS  load value, digit 0 in bits [3:0].
- oTICK  out  1  one-cycle pulse every DIV clocks.
- oSIG  out  1  square wave at TICK_HZ.
- oBCD  out  4*DIGITS  counter value, digit 0 in bits [3:0].
- oCARRY  out  1  one-cycle pulse on full-range wrap.

Behaviour:

Reset (iRST_N low, asynchronous):
- Prescaler = 0, all digits = 0, oTICK = 0, oSIG = 0, oCARRY = 0.
- Release is synchronous to the next rising edge.

Prescaler:
- Width clog2(DIV). Counts 0..DIV-1 and wraps to 0.
- oTICK is registered: high for exactly the one cycle after the prescaler holds DIV-1.
- oSIG is registered: high when prescaler < DIV/2 (integer division), otherwise low. Period is DIV clocks.
- The prescaler free-runs regardless of iEN, iUP and iLOAD.

Counter priority, per cycle:
1. iCLR: all digits = 0, prescaler = 0, oCARRY = 0.
2. iLOAD: digits = iLOAD_VAL. Any loaded nibble > 9 becomes 0. oCARRY = 0. The prescaler is not affected.
3. Tick cycle (oTICK high) and iEN = 1: count one step in direction iUP.
4. Otherwise: hold.
- A tick coinciding with iCLR or iLOAD is lost, with no deferred count.

Up count:
- Digit 0 increments.
- A digit at 9 goes to 0 and carries into the next digit.
- When all digits are 9, the counter goes to all 0 and oCARRY pulses for one cycle.

Down count:
- Digit 0 decrements.
- A digit at 0 goes to 9 and borrows from the next digit.
- When all digits are 0, the counter goes to all 9 and oCARRY pulses for one cycle.

Timing and sampling:
- oBCD and oCARRY update in the same clock edge that samples the tick, so they change one cycle after oTICK rises.
- iUP is sampled on the tick cycle only; changing it between ticks has no effect.

Implementation constraints:
- No derived or gated clocks. Every register is clocked by iCLK; the tick is used only as an enable.
- oBCD never holds a nibble > 9.

Test Plan (bench params CLK_HZ=20, TICK_HZ=2, DIGITS=2, so DIV=10):
1. Reset, then free-run 40 clocks with iEN=0 -> oTICK pulses every 10 clocks, oSIG is high 5 clocks and low 5 clocks, oBCD stays 8'h00.
2. iEN=1, iUP=1 for 100 ticks starting from 00 -> oBCD steps 00,01..09,10..99,00. oCARRY is high exactly once, one cycle, on the 99->00 step.
3. iLOAD with iLOAD_VAL=8'h00, then iUP=0, 2 ticks -> 99 with oCARRY pulse, then 98. Load 8'h10 and 1 down tick -> 09.
4. Load 8'hA5 -> oBCD = 8'h05. Load 8'h3F -> oBCD = 8'h30.
5. iCLR and iLOAD asserted together on a tick cycle with counter at 8'h42 -> oBCD = 00, prescaler = 0, and the next oTICK arrives 10 clocks later.
6. Assert iRST_N low mid-count at 8'h57, asynchronously between clock edges -> oBCD, oTICK, oSIG and oCARRY go to 0 immediately. After release, counting resumes from 00 on the 10th clock.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// bcd_tick_counter
//
// Purpose:
//   A prescaler divides iCLK down to a one-cycle tick enable. A chain of DIGITS
//   cascaded BCD digits counts up or down on that tick. Also provides parallel
//   load, synchronous clear, count enable and a one-cycle wrap/carry pulse.
//   Everything runs in the iCLK domain; the tick is only ever used as an enable.
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  tick rate in Hz; DIV = CLK_HZ / TICK_HZ must be an integer >= 2
//   DIGITS   number of cascaded BCD digits, 1..8
//
// Ports:
//   iCLK       in   system clock, rising edge
//   iRST_N     in   asynchronous active-low reset
//   iEN        in   count enable, only looked at on tick cycles
//   iUP        in   direction, 1 = up, 0 = down (sampled on tick cycles)
//   iCLR       in   synchronous clear of counter and prescaler (highest priority)
//   iLOAD      in   synchronous parallel load of the counter
//   iLOAD_VAL  in   load value, digit 0 in bits [3:0]; nibbles > 9 load as 0
//   oTICK      out  one-cycle pulse every DIV clocks
//   oSIG       out  square wave at TICK_HZ
//   oBCD       out  counter value, digit 0 in bits [3:0]
//   oCARRY     out  one-cycle pulse when the full range wraps
//
// Handshake: none. Every input is a level sampled on each rising edge of iCLK;
// there is no valid/ready flow control on this block.
// -----------------------------------------------------------------------------
module bcd_tick_counter #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 4,
    parameter int DIGITS  = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iEN,
    input  logic                  iUP,
    input  logic                  iCLR,
    input  logic                  iLOAD,
    input  logic [4*DIGITS-1:0]   iLOAD_VAL,
    output logic                  oTICK,
    output logic                  oSIG,
    output logic [4*DIGITS-1:0]   oBCD,
    output logic                  oCARRY
);

    localparam int DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(DIV / 2);

    // Refuse to elaborate with a divider that does not yield an exact tick
    // rate, or with an unsupported digit count.
    if (TICK_HZ <= 0 || (CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : gBadDiv
        $error("bcd_tick_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : gBadDigits
        $error("bcd_tick_counter: DIGITS must be in 1..8");
    end

    // -------------------------------------------------------------------------
    // Prescaler: free-running 0..DIV-1. oTICK and oSIG are registered views of
    // the prescaler, so both lag it by one cycle. A clear puts the prescaler,
    // tick and square wave back into their reset state so the tick cadence
    // after a clear is identical to the cadence after reset.
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            presc <= '0;
            oTICK <= 1'b0;
            oSIG  <= 1'b0;
        end else if (iCLR) begin
            presc <= '0;
            oTICK <= 1'b0;
            oSIG  <= 1'b0;
        end else begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
            oTICK <= (presc == LAST);
            oSIG  <= (presc < HALF);
        end
    end

    // -------------------------------------------------------------------------
    // Next-value logic for the digit chain.
    // -------------------------------------------------------------------------
    logic [4*DIGITS-1:0] loadClean;
    logic [4*DIGITS-1:0] stepVal;
    logic                stepWrap;
    logic                chain;

    // Loaded nibbles outside 0..9 are forced to 0 so oBCD always holds BCD.
    always_comb begin
        loadClean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            loadClean[4*i +: 4] = (iLOAD_VAL[4*i +: 4] > 4'd9) ? 4'd0
                                                               : iLOAD_VAL[4*i +: 4];
        end
    end

    // Ripple carry/borrow: `chain` is true while every lower digit has wrapped.
    // If it survives past the top digit the whole range wrapped.
    always_comb begin
        stepVal = oBCD;
        chain   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain) begin
                if (iUP) begin
                    if (oBCD[4*i +: 4] == 4'd9) begin
                        stepVal[4*i +: 4] = 4'd0;
                    end else begin
                        stepVal[4*i +: 4] = oBCD[4*i +: 4] + 4'd1;
                        chain             = 1'b0;
                    end
                end else begin
                    if (oBCD[4*i +: 4] == 4'd0) begin
                        stepVal[4*i +: 4] = 4'd9;
                    end else begin
                        stepVal[4*i +: 4] = oBCD[4*i +: 4] - 4'd1;
                        chain             = 1'b0;
                    end
                end
            end
        end
        stepWrap = chain;
    end

    // -------------------------------------------------------------------------
    // Counter register. Priority: clear, load, tick+enable, hold.
    // A tick that lands on a clear or load cycle is dropped.
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oBCD   <= '0;
            oCARRY <= 1'b0;
        end else if (iCLR) begin
            oBCD   <= '0;
            oCARRY <= 1'b0;
        end else if (iLOAD) begin
            oBCD   <= loadClean;
            oCARRY <= 1'b0;
        end else if (oTICK && iEN) begin
            oBCD   <= stepVal;
            oCARRY <= stepWrap;
        end else begin
            oCARRY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_tick_counter
//
// Directed bench for bcd_tick_counter with CLK_HZ=20, TICK_HZ=2, DIGITS=2
// (DIV=10). A small decimal-arithmetic reference model predicts each cycle's
// {oCARRY, oTICK, oSIG, oBCD}; the prediction is queued when the inputs are
// driven and popped and compared after the edge. Directed checks cover the
// boundary cases: wrap in both directions, load sanitising, clear+load on a
// tick, and asynchronous reset mid-count.
// -----------------------------------------------------------------------------
module tb_bcd_tick_counter;

    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 2;
    localparam int DIGITS  = 2;
    localparam int W       = 4 * DIGITS;

    // ---------------- clock / reset ----------------
    logic         iCLK = 1'b0;
    logic         iRST_N = 1'b0;
    logic         iEN = 1'b0;
    logic         iUP = 1'b1;
    logic         iCLR = 1'b0;
    logic         iLOAD = 1'b0;
    logic [W-1:0] iLOAD_VAL = '0;
    logic         oTICK;
    logic         oSIG;
    logic [W-1:0] oBCD;
    logic         oCARRY;

    always #5 iCLK = ~iCLK;

    bcd_tick_counter #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .DIGITS  (DIGITS)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iEN       (iEN),
        .iUP       (iUP),
        .iCLR      (iCLR),
        .iLOAD     (iLOAD),
        .iLOAD_VAL (iLOAD_VAL),
        .oTICK     (oTICK),
        .oSIG      (oSIG),
        .oBCD      (oBCD),
        .oCARRY    (oCARRY)
    );

    // ---------------- scoreboard state ----------------
    logic [W+2:0] exp_q[$];
    int nAsserts = 0;
    int nFails   = 0;

    // reference model state
    int mPresc = 0;
    int mVal   = 0;
    bit mTick  = 0;
    bit mSig   = 0;
    bit mCarry = 0;

    int ticksUsed = 0;
    int carrySeen = 0;
    int tickSeen  = 0;
    int sigSeen   = 0;

    function automatic logic [W-1:0] toBcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int loadToInt(input logic [W-1:0] lv);
        int hi;
        int lo;
        hi = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver: one clock with model prediction ----------------
    task automatic cycle();
        int nPresc;
        int nVal;
        bit nTick;
        bit nSig;
        bit nCarry;
        logic [W+2:0] obs;
        logic [W+2:0] expv;
        if (iCLR) begin
            nPresc = 0; nTick = 0; nSig = 0; nVal = 0; nCarry = 0;
        end else begin
            nPresc = (mPresc == 9) ? 0 : mPresc + 1;
            nTick  = (mPresc == 9);
            nSig   = (mPresc < 5);
            nVal   = mVal;
            nCarry = 0;
            if (iLOAD) begin
                nVal = loadToInt(iLOAD_VAL);
            end else if (mTick && iEN) begin
                if (iUP) begin
                    nVal   = (mVal + 1) % 100;
                    nCarry = (mVal == 99);
                end else begin
                    nVal   = (mVal + 99) % 100;
                    nCarry = (mVal == 0);
                end
                ticksUsed++;
            end
        end
        exp_q.push_back({nCarry, nTick, nSig, toBcd(nVal)});
        @(posedge iCLK);
        #1;
        mPresc = nPresc; mTick = nTick; mSig = nSig; mVal = nVal; mCarry = nCarry;
        obs  = {oCARRY, oTICK, oSIG, oBCD};
        expv = exp_q.pop_front();
        check("cycle", 32'(obs), 32'(expv));
        if (oCARRY) carrySeen++;
        if (oTICK)  tickSeen++;
        if (oSIG)   sigSeen++;
    endtask

    task automatic runTicks(input int n);
        int start;
        int guard;
        start = ticksUsed;
        guard = 0;
        while ((ticksUsed - start) < n && guard < 15 * n + 20) begin
            cycle();
            guard++;
        end
        check("ticks_done", 32'(ticksUsed - start), 32'(n));
    endtask

    task automatic loadValue(input logic [W-1:0] v);
        iLOAD     = 1'b1;
        iLOAD_VAL = v;
        cycle();
        iLOAD     = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int guard;
        int start;

        // Reset state
        #12;
        check("reset_outputs", 32'({oCARRY, oTICK, oSIG, oBCD}), 32'd0);
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;

        // 1. free-run 40 clocks with iEN=0
        tickSeen = 0; sigSeen = 0;
        for (int i = 0; i < 40; i++) cycle();
        check("t1_tick_count", 32'(tickSeen), 32'd4);
        check("t1_sig_high", 32'(sigSeen), 32'd20);
        check("t1_bcd_hold", 32'(oBCD), 32'h00);

        // 2. 100 up ticks from 00; iUP toggles randomly off the tick cycles
        iEN = 1'b1;
        carrySeen = 0;
        start = ticksUsed;
        guard = 0;
        while ((ticksUsed - start) < 100 && guard < 1200) begin
            iUP = mTick ? 1'b1 : 1'($urandom_range(0, 1));
            cycle();
            guard++;
        end
        iUP = 1'b1;
        check("t2_ticks", 32'(ticksUsed - start), 32'd100);
        check("t2_wrap_bcd", 32'(oBCD), 32'h00);
        check("t2_wrap_carry", 32'(oCARRY), 32'd1);
        check("t2_carry_once", 32'(carrySeen), 32'd1);

        // 3. down count across the wrap
        iUP = 1'b0;
        loadValue(8'h00);
        check("t3_load00", 32'(oBCD), 32'h00);
        runTicks(1);
        check("t3_down_wrap_bcd", 32'(oBCD), 32'h99);
        check("t3_down_wrap_carry", 32'(oCARRY), 32'd1);
        runTicks(1);
        check("t3_down_98", 32'(oBCD), 32'h98);
        check("t3_carry_gone", 32'(oCARRY), 32'd0);
        loadValue(8'h10);
        runTicks(1);
        check("t3_borrow_09", 32'(oBCD), 32'h09);

        // 4. load sanitising
        iEN = 1'b0;
        loadValue(8'hA5);
        check("t4_load_A5", 32'(oBCD), 32'h05);
        loadValue(8'h3F);
        check("t4_load_3F", 32'(oBCD), 32'h30);

        // 5. clear + load together on a tick cycle at 42
        loadValue(8'h42);
        guard = 0;
        while (!mTick && guard < 20) begin
            cycle();
            guard++;
        end
        check("t5_at_tick", 32'(oTICK), 32'd1);
        check("t5_pre_42", 32'(oBCD), 32'h42);
        iEN = 1'b1; iUP = 1'b1;
        iCLR = 1'b1; iLOAD = 1'b1; iLOAD_VAL = 8'h77;
        cycle();
        iCLR = 1'b0; iLOAD = 1'b0;
        check("t5_clear_bcd", 32'(oBCD), 32'h00);
        n = 0;
        while (!oTICK && n < 20) begin
            cycle();
            n++;
        end
        check("t5_next_tick_gap", 32'(n), 32'd10);

        // 6. asynchronous reset mid-count at 57
        loadValue(8'h56);
        runTicks(1);
        check("t6_at_57", 32'(oBCD), 32'h57);
        cycle();
        cycle();
        #3;
        iRST_N = 1'b0;
        #1;
        check("t6_async_reset", 32'({oCARRY, oTICK, oSIG, oBCD}), 32'd0);
        mPresc = 0; mTick = 0; mSig = 0; mVal = 0; mCarry = 0;
        @(posedge iCLK);
        #1;
        check("t6_reset_held", 32'({oCARRY, oTICK, oSIG, oBCD}), 32'd0);
        iRST_N = 1'b1;
        n = 0;
        while (!oTICK && n < 20) begin
            cycle();
            n++;
        end
        check("t6_first_tick", 32'(n), 32'd10);
        check("t6_still_00", 32'(oBCD), 32'h00);
        cycle();
        check("t6_resume_01", 32'(oBCD), 32'h01);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
